// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
package seg7_pkg;
  typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic int cnt_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// bcd_to_7seg: nibble to active-low {a,b,c,d,e,f,g} glyph, hex digits included.
module bcd_to_7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (bcd)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode display scanner with guard band and double-buffered data.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lzb_en,
  output logic                    ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int CW = cnt_w(PRESCALE);
  localparam int DW = $clog2(NUM_DIGITS);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] dig, dig_n;
  logic [4*NUM_DIGITS-1:0] act_d, act_d_n, sh_d;
  logic [NUM_DIGITS-1:0] act_m, act_m_n, sh_m, dark, an_n;
  logic pending, slot_end, wrap, commit, accept, lz;
  logic [3:0] nib;
  logic [6:0] glyph, seg_n;
  always_comb begin
    slot_end = state == DRIVE && cnt == CW'(PRESCALE - 1);
    wrap     = en && slot_end && dig == DW'(NUM_DIGITS - 1);
    state_n  = !en ? OFF
             : state == OFF ? BLANK
             : (state == BLANK && cnt == CW'(GUARD - 1)) ? DRIVE
             : slot_end ? BLANK : state;
    cnt_n    = (!en || state == OFF || slot_end) ? '0 : cnt + 1'b1;
    dig_n    = (!en || state == OFF) ? '0
             : slot_end ? (dig == DW'(NUM_DIGITS - 1) ? '0 : dig + 1'b1) : dig;
    commit   = pending && (wrap || state == OFF);
    accept   = load && !pending;
    act_d_n  = commit ? sh_d : act_d;
    act_m_n  = commit ? sh_m : act_m;
  end
  // Leading-zero run propagates down from the top digit; digit 0 is never part of it.
  always_comb begin
    dark = act_m_n;
    lz   = lzb_en;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz      = lz && act_d_n[4*i +: 4] == 4'd0;
      dark[i] = dark[i] | lz;
    end
  end
  assign nib = act_d_n[{dig_n, 2'b00} +: 4];
  bcd_to_7seg u_dec (.bcd(nib), .seg(glyph));
  always_comb begin
    an_n  = state_n == DRIVE ? ~(NUM_DIGITS'(1) << dig_n) : '1;
    seg_n = (state_n == DRIVE && !dark[dig_n]) ? glyph : SEG_BLANK;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OFF;
      cnt        <= '0;
      dig        <= '0;
      act_d      <= '0;
      act_m      <= '0;
      sh_d       <= '0;
      sh_m       <= '0;
      pending    <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dig        <= dig_n;
      act_d      <= act_d_n;
      act_m      <= act_m_n;
      sh_d       <= accept ? data_in : sh_d;
      sh_m       <= accept ? blank_mask : sh_m;
      pending    <= accept | (pending & ~commit);
      an         <= an_n;
      seg        <= seg_n;
      frame_tick <= wrap;
    end
  end
  assign ready = ~pending;
endmodule
